// File: rtl/sweep_pkg.sv
// Shared types and helpers for exhaustive truth-table sweep stages.
// SWEEP_GRAY_ORDER_EN selects reflected-Gray visiting order in step_to_vec.
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int DWELL_MIN = 2;

  // Maps a binary step index onto the vector driven at that step.
  function automatic int unsigned step_to_vec(input int unsigned step);
`ifdef SWEEP_GRAY_ORDER_EN
    return step ^ (step >> 1);
`else
    return step;
`endif
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Up-counter holding a stimulus for a fixed number of cycles.
// tc flags the last cycle of the dwell (count == DWELL-1).
module dwell_counter #(
  parameter int DWELL = 10,
  localparam int W = (DWELL > 1) ? $clog2(DWELL) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) count <= '0;
    else if (en)      count <= count + 1'b1;
  end

  assign tc = (count == W'(DWELL - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus/response checker around a small combinational circuit.
// Define SWEEP_GRAY_ORDER_EN to visit vectors in Gray order (same cycle counts).
//
// state  | meaning
// IDLE   | waiting for start; results of the last sweep held
// DRIVE  | stim held while the dwell counter runs
// SAMPLE | capture dut_g for stim, compare, advance to next vector
// FINISH | pulse done, publish pass, rewind to vector 0
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int DWELL = 10,
  parameter logic [(2**N_IN)-1:0] EXP_TT = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [N_IN-1:0]        stim,
  input  logic                   dut_g,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N_IN:0]          err_count,
  output logic [N_IN-1:0]        fail_vec,
  output logic                   fail_valid,
  output logic [(2**N_IN)-1:0]   captured
);

  localparam int DWELL_EFF = (DWELL < DWELL_MIN) ? DWELL_MIN : DWELL;
  localparam logic [N_IN:0]   ERR_MAX   = (N_IN + 1)'(2**N_IN);
  localparam logic [N_IN-1:0] STEP_LAST = '1;

  state_t          state, state_nxt;
  logic [N_IN-1:0] step;
  logic [N_IN-1:0] step_nxt;
  logic [N_IN-1:0] vec_nxt;
  logic            cnt_clear, cnt_en, cnt_tc;

  dwell_counter #(.DWELL(DWELL_EFF)) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  assign step_nxt = step + 1'b1;
  assign vec_nxt  = N_IN'(step_to_vec(32'(step_nxt)));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = DRIVE;
          cnt_clear = 1'b1;
        end
      end
      DRIVE: begin
        cnt_en = !cnt_tc;
        if (cnt_tc) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        cnt_clear = 1'b1;
        state_nxt = (step == STEP_LAST) ? FINISH : DRIVE;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step       <= '0;
      stim       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_vec   <= '0;
      fail_valid <= 1'b0;
      captured   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            step       <= '0;
            stim       <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            captured   <= '0;
            pass       <= 1'b0;
            busy       <= 1'b1;
          end
        end
        SAMPLE: begin
          captured[stim] <= dut_g;
          if (dut_g != EXP_TT[stim]) begin
            if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
            if (!fail_valid) begin
              fail_vec   <= stim;
              fail_valid <= 1'b1;
            end
          end
          // The last vector stays on stim until FINISH rewinds it.
          if (step != STEP_LAST) begin
            step <= step_nxt;
            stim <= vec_nxt;
          end
        end
        FINISH: begin
          done <= 1'b1;
          busy <= 1'b0;
          pass <= (err_count == '0);
          step <= '0;
          stim <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: three sweepers (AND4 / XOR4 / XOR4 with one wrong entry) run in lockstep.
// Build with SWEEP_GRAY_ORDER_EN to check Gray visiting order instead of binary.
module tb_truth_table_sweeper;

  localparam logic [47:0] TTS = {16'h6997, 16'h6996, 16'h8000};

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        force_one;
  logic [2:0]  dut_g;
  logic [3:0]  stim [3];
  logic        busy [3];
  logic        done [3];
  logic        pass [3];
  logic [4:0]  err_count [3];
  logic [3:0]  fail_vec [3];
  logic        fail_valid [3];
  logic [15:0] captured [3];

  int vectors = 0;
  int errs = 0;
  int fd, nd;

  always #5 clk = ~clk;

  assign dut_g[0] = force_one | (&stim[0]);
  assign dut_g[1] = ^stim[1];
  assign dut_g[2] = ^stim[2];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    truth_table_sweeper #(.N_IN(4), .DWELL(10), .EXP_TT(TTS[g*16 +: 16])) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stim       (stim[g]),
      .dut_g      (dut_g[g]),
      .busy       (busy[g]),
      .done       (done[g]),
      .pass       (pass[g]),
      .err_count  (err_count[g]),
      .fail_vec   (fail_vec[g]),
      .fail_valid (fail_valid[g]),
      .captured   (captured[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulses start, then watches 200 cycles. glitch_at re-pulses start while busy;
  // rst_at asserts rst after that cycle and returns early.
  task automatic run_sweep(input int glitch_at, input int rst_at,
                           output int first_done, output int n_done);
    int k, exp_vec;
    first_done = -1;
    n_done = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (done[0]) begin
        n_done++;
        if (first_done < 0) first_done = c;
      end
      if (c <= 175 && (c % 11) == 5) begin
        k = c / 11;
`ifdef SWEEP_GRAY_ORDER_EN
        exp_vec = k ^ (k >> 1);
`else
        exp_vec = k;
`endif
        check("stim_order", 32'(stim[0]), 32'(exp_vec));
      end
      start = (c == glitch_at);
      if (rst_at > 0 && c == rst_at) begin
        rst = 1'b1;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_stim"},       32'(stim[0]),       32'h0);
    check({tag, "_busy"},       32'(busy[0]),       32'h0);
    check({tag, "_done"},       32'(done[0]),       32'h0);
    check({tag, "_pass"},       32'(pass[0]),       32'h0);
    check({tag, "_err_count"},  32'(err_count[0]),  32'h0);
    check({tag, "_fail_vec"},   32'(fail_vec[0]),   32'h0);
    check({tag, "_fail_valid"}, 32'(fail_valid[0]), 32'h0);
    check({tag, "_captured"},   32'(captured[0]),   32'h0);
  endtask

  task automatic check_and_clean(input string tag);
    check({tag, "_pass"},       32'(pass[0]),       32'h1);
    check({tag, "_err_count"},  32'(err_count[0]),  32'h0);
    check({tag, "_captured"},   32'(captured[0]),   32'h8000);
    check({tag, "_fail_valid"}, 32'(fail_valid[0]), 32'h0);
    check({tag, "_busy"},       32'(busy[0]),       32'h0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    force_one = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // AND4 against 8000, XOR4 against 6996 and 6997
    run_sweep(0, 0, fd, nd);
    check("s1_done_cycle", 32'(fd), 32'd177);
    check("s1_done_count", 32'(nd), 32'd1);
    check_and_clean("s1_and");
    check("s3_xor_pass",        32'(pass[1]),       32'h1);
    check("s3_xor_err",         32'(err_count[1]),  32'h0);
    check("s3_xor_captured",    32'(captured[1]),   32'h6996);
    check("s3_xor1_pass",       32'(pass[2]),       32'h0);
    check("s3_xor1_err",        32'(err_count[2]),  32'h1);
    check("s3_xor1_fail_vec",   32'(fail_vec[2]),   32'h0);
    check("s3_xor1_fail_valid", 32'(fail_valid[2]), 32'h1);

    // G stuck at 1
    force_one = 1'b1;
    run_sweep(0, 0, fd, nd);
    force_one = 1'b0;
    check("s2_done_cycle", 32'(fd),             32'd177);
    check("s2_err_count",  32'(err_count[0]),   32'd15);
    check("s2_fail_vec",   32'(fail_vec[0]),    32'h0);
    check("s2_fail_valid", 32'(fail_valid[0]),  32'h1);
    check("s2_pass",       32'(pass[0]),        32'h0);
    check("s2_captured",   32'(captured[0]),    32'hFFFF);

    // reset mid-DRIVE of vector 7 (cycle 80 = 7*11+3)
    run_sweep(0, 80, fd, nd);
    check("s4_no_done_before_rst", 32'(nd), 32'd0);
    @(negedge clk);
    check_zero("s4_rst");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("s4_idle_busy", 32'(busy[0]), 32'h0);
    check("s4_idle_stim", 32'(stim[0]), 32'h0);
    run_sweep(0, 0, fd, nd);
    check("s4_done_cycle", 32'(fd), 32'd177);
    check_and_clean("s4_clean");

    // start while busy is ignored
    run_sweep(50, 0, fd, nd);
    check("s5_done_cycle", 32'(fd), 32'd177);
    check("s5_done_count", 32'(nd), 32'd1);
    check_and_clean("s5");

    // start together with rst: rst wins
    @(negedge clk);
    start = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    check("s5_rst_start_busy", 32'(busy[0]), 32'h0);
    repeat (3) @(negedge clk);
    check("s5_rst_start_idle_busy", 32'(busy[0]), 32'h0);
    check("s5_rst_start_stim",      32'(stim[0]), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Self-checking stimulus/response stage wrapped around a 4-input combinational circuit under test (inputs A..D, output G).
- Drives every input combination in turn, holds each for a programmable dwell time and samples the circuit's output.
- Compares each sample against a parameterised expected truth table and reports pass/fail with the first failing vector.
- Sits directly upstream (drives the DUT inputs) and downstream (consumes G) of the combinational circuit; it replaces the hand-written exhaustive stimulus sequence in synthesizable form.

Parameters:
- N_IN, 4, number of DUT inputs; the sweep covers 2**N_IN vectors.
- DWELL, 10, clock cycles each vector is held (minimum 2).
- EXP_TT, 16'h0000, expected output; bit i is the expected G for input vector i (A = MSB).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a sweep when idle.
- stim  output  N_IN  drives DUT inputs {A,B,C,D}; registered.
- dut_g  input  1  DUT output G.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse at sweep completion.
- pass  output  1  valid from done until next start; 1 when err_count == 0.
- err_count  output  N_IN+1  number of mismatching vectors (0..2**N_IN).
- fail_vec  output  N_IN  first mismatching vector; valid when fail_valid is high.
- fail_valid  output  1  set at the first mismatch, held until the next start.
- captured  output  2**N_IN  captured[i] = sampled G for vector i.

Behaviour:
- Reset: stim=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, fail_valid=0, captured=0; FSM enters IDLE. Reset mid-sweep aborts immediately with these same values.
- FSM states: IDLE, DRIVE, SAMPLE, FINISH.
- IDLE: on start, go to DRIVE. In the same edge: stim=0, dwell counter=0, err_count/fail_valid/captured cleared, pass=0, busy=1.
- DRIVE: stim held constant and the dwell counter increments each cycle. When the counter reaches DWELL-1, go to SAMPLE.
- SAMPLE (one cycle): captured[stim] <= dut_g.
  - On mismatch with EXP_TT[stim]: err_count += 1; if fail_valid == 0, fail_vec <= stim and fail_valid <= 1.
  - If stim is the last vector, go to FINISH. Otherwise advance stim to the next vector, clear the counter and return to DRIVE.
- Per-vector period is DWELL+1 cycles. Total sweep from start to done is 2**N_IN*(DWELL+1)+1 cycles.
- FINISH (one cycle): done=1, busy=0, pass=(err_count==0). Next state is IDLE.
- Vector order: binary ascending 0..2**N_IN-1. The stim counter wraps only in FINISH, never mid-sweep.
- start while busy is ignored. start in the same cycle as rst: rst wins.
- err_count saturates at 2**N_IN, which is reachable only if every vector fails.
- DUT latency: dut_g is treated as combinational from stim; sampling at the end of the dwell absorbs any settling.

Optional Feature:
- Macro SWEEP_GRAY_ORDER_EN.
- When defined, vectors are visited in reflected-Gray order (bin ^ (bin>>1)), so only one DUT input toggles per step. captured and fail_vec are still indexed and reported by the actual vector value.
- When undefined, vectors are visited in binary ascending order.
- Cycle counts are identical in both builds.

Decomposition:
- Shared package sweep_pkg: FSM state enum (IDLE, DRIVE, SAMPLE, FINISH), DWELL_MIN=2 constant, and a function mapping a binary step index to a vector (binary or Gray).
- One natural sub-module: dwell_counter (load/clear, enable, terminal-count flag at DWELL-1), reusable by other sweep stages.

Test Plan:
1. EXP_TT=16'h8000, DUT = A&B&C&D: start -> done after 177 cycles (DWELL=10); pass=1, err_count=0, captured=16'h8000, fail_valid=0.
2. Same EXP_TT, DUT forced to G=1: err_count=15, fail_vec=4'h0, fail_valid=1, pass=0, captured=16'hFFFF.
3. DUT = A^B^C^D with EXP_TT=16'h6996 -> pass=1. Repeat with EXP_TT=16'h6997 -> err_count=1, fail_vec=4'h0.
4. Assert rst at vector 7 mid-DRIVE: next cycle all outputs zero and FSM in IDLE. A subsequent start gives a full clean sweep with the correct result.
5. Pulse start again at cycle 50 while busy: no effect; done still occurs exactly once, at cycle 177. start and rst asserted together: stays IDLE.
6. With SWEEP_GRAY_ORDER_EN defined: stim sequence 0,1,3,2,6,... with exactly one bit changing per step; captured and pass match scenario 1.
